// File: rtl/vector_unit_pkg.sv
// Shared types for the vector unit: element partition, packed product vector,
// accumulator operation encodings and byte/product extension helpers.
package vector_unit_pkg;

  typedef enum logic [1:0] {
    BIT8      = 2'b00,
    BIT16     = 2'b01,
    ESZ_RSVD2 = 2'b10,
    ESZ_RSVD3 = 2'b11
  } esize_t;

  typedef union packed {
    logic [1:0][31:0] vect2;
    logic [3:0][15:0] vect4;
  } vmul_vector_t;

  localparam logic ACCUMULATE = 1'b0;
  localparam logic SATURATE   = 1'b1;

  localparam int unsigned NUM_PP = 8;

  function automatic logic signed [8:0] ext_byte(input logic [7:0] b, input logic sx);
    return {sx & b[7], b};
  endfunction

  function automatic logic [31:0] sext_pp(input logic signed [17:0] p);
    return {{14{p[17]}}, p};
  endfunction

endpackage

// File: rtl/vector_partial_product.sv
// Combinational 9x9 signed multiplier producing one byte-pair partial product.
module vector_partial_product (
  input  logic signed [8:0]  a_i,
  input  logic signed [8:0]  b_i,
  output logic signed [17:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/vector_multiplier.sv
// Two-stage packed SIMD multiplier: stage 1 registers eight byte partial
// products, stage 2 combines them into 4x16-bit or 2x32-bit results.
module vector_multiplier
  import vector_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [31:0]  operand_A_i,
  input  logic [31:0]  operand_B_i,
  input  esize_t       element_size_i,
  input  logic         signed_i,
  input  logic         operation_i,
  input  logic [31:0]  reg_destination_i,
  input  logic         data_valid_i,
  input  logic         stall_i,
  input  logic         flush_i,
  output vmul_vector_t vmul_result_o,
  output esize_t       element_size_o,
  output logic         operation_o,
  output logic [31:0]  reg_destination_o,
  output logic         data_valid_o
);

  logic signed [8:0]  a_ext [4];
  logic signed [8:0]  b_ext [4];
  logic signed [17:0] pp_d  [NUM_PP];
  logic signed [17:0] pp_q  [NUM_PP];

  logic         s1_valid_q, s1_valid_d;
  esize_t       s1_esize_q;
  logic         s1_op_q;
  logic [31:0]  s1_rd_q;

  logic         s2_valid_q, s2_valid_d;
  vmul_vector_t res_d, res_q;
  esize_t       s2_esize_q;
  logic         s2_op_q;
  logic [31:0]  s2_rd_q;

  logic         s1_load, s2_load;

  // In BIT16 mode only the high byte of each halfword carries the sign.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      a_ext[k] = ext_byte(operand_A_i[8*k +: 8],
                          signed_i & ((element_size_i == BIT8) | (k % 2 == 1)));
      b_ext[k] = ext_byte(operand_B_i[8*k +: 8],
                          signed_i & ((element_size_i == BIT8) | (k % 2 == 1)));
    end
  end

  // Per lane i: pp[4i+0]=lo*lo, [4i+1]=lo*hi, [4i+2]=hi*lo, [4i+3]=hi*hi.
  // In BIT8 mode lo*lo and hi*hi are exactly the byte-wise products.
  for (genvar i = 0; i < 2; i++) begin : g_lane
    for (genvar t = 0; t < 4; t++) begin : g_pp
      vector_partial_product u_pp (
        .a_i (a_ext[2*i + t/2]),
        .b_i (b_ext[2*i + t%2]),
        .p_o (pp_d[4*i + t])
      );
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (!stall_i) begin
      s1_valid_d = data_valid_i;
      s2_valid_d = s1_valid_q;
    end
  end

  assign s1_load = !stall_i && data_valid_i;
  assign s2_load = !stall_i && s1_valid_q;

  always_comb begin
    res_d = '0;
    case (s1_esize_q)
      BIT8: begin
        for (int unsigned i = 0; i < 2; i++) begin
          res_d.vect4[2*i]     = pp_q[4*i][15:0];
          res_d.vect4[2*i + 1] = pp_q[4*i + 3][15:0];
        end
      end
      BIT16: begin
        for (int unsigned i = 0; i < 2; i++) begin
          res_d.vect2[i] = (sext_pp(pp_q[4*i + 3]) << 16)
                         + ((sext_pp(pp_q[4*i + 1]) + sext_pp(pp_q[4*i + 2])) << 8)
                         + sext_pp(pp_q[4*i]);
        end
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_esize_q <= BIT8;
      s1_op_q    <= ACCUMULATE;
      s1_rd_q    <= '0;
      for (int unsigned m = 0; m < NUM_PP; m++) pp_q[m] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_esize_q <= element_size_i;
        s1_op_q    <= operation_i;
        s1_rd_q    <= reg_destination_i;
        for (int unsigned m = 0; m < NUM_PP; m++) pp_q[m] <= pp_d[m];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      s2_esize_q <= BIT8;
      s2_op_q    <= ACCUMULATE;
      s2_rd_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        res_q      <= res_d;
        s2_esize_q <= s1_esize_q;
        s2_op_q    <= s1_op_q;
        s2_rd_q    <= s1_rd_q;
      end
    end
  end

  assign vmul_result_o     = res_q;
  assign element_size_o    = s2_esize_q;
  assign operation_o       = s2_op_q;
  assign reg_destination_o = s2_rd_q;
  assign data_valid_o      = s2_valid_q;

endmodule
